// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment frame buffer.
// The helper lead_zero_mask is used only when LEADING_ZERO_BLANK_EN is defined.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment pattern, bit order g..a
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF     = 7'h7F;
  localparam logic [7:0] ANODE_RESET = 8'hFE;

  // One displayable frame: eight hex nibbles, decimal points, blank mask
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } frame_t;

  // Power-up frame: everything blanked, so the display stays dark
  localparam frame_t FRAME_RESET = '{value: 32'h0, dp: 8'h00, blank: 8'hFF};

  // Blank every digit above the highest nonzero nibble; digit 0 always shows
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] value);
    logic [7:0] mask;
    logic       seen;
    mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (value[4*k +: 4] != 4'h0) seen = 1'b1;
      mask[k] = ~seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup; default keeps every segment dark
  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_frame_buffer.sv
// Double-buffered 8-digit seven-segment frame source with its own scan timing.
// A frame is written into a shadow buffer through a valid/ready handshake and
// is promoted to the active buffer only when the scan wraps from digit 7 to 0,
// so a frame is never shown half old / half new.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module display_frame_buffer
  import display_pkg::*;
#(
  parameter int TICK_DIV   = 250000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_value,
  input  logic [NUM_DIGITS-1:0] wr_dp,
  input  logic [NUM_DIGITS-1:0] wr_blank,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [7:0]            data,
  output logic                  frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         PS_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]         PS_ONE    = PW'(1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic          tick;
  logic          frame_wrap;
  logic          swap;
  logic          accept;
  logic          pending;

  frame_t        active;
  frame_t        shadow;
  frame_t        shadow_eff;
  frame_t        src;
  logic [3:0]    nibble;
  seg_t          seg;
  logic [7:0]    data_next;

  assign tick       = (prescaler == PS_LAST);
  assign idx_next   = idx + 3'd1;
  assign frame_wrap = tick && (idx == 3'd7);
  // A swap needs pending=1 and a write needs pending=0, so they never collide
  assign swap       = frame_wrap && pending;
  assign accept     = wr_valid && !pending;
  assign wr_ready   = ~pending;

`ifdef LEADING_ZERO_BLANK_EN
  // Fold the auto leading-zero mask into the frame as it is promoted
  always_comb begin
    shadow_eff       = shadow;
    shadow_eff.blank = shadow.blank | lead_zero_mask(shadow.value);
  end
`else
  assign shadow_eff = shadow;
`endif

  // The digit being loaded on a swap edge must already see the new frame
  assign src    = swap ? shadow_eff : active;
  assign nibble = src.value[{idx_next, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg)
  );

  // Cathode pattern for the digit that becomes active at the next tick edge
  always_comb begin
    data_next = 8'hFF;
    if (!src.blank[idx_next]) data_next = {~src.dp[idx_next], seg};
  end

  // Digit-slot prescaler: tick cycle is the last count before wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PS_ONE;
    end
  end

  // Scan stage: index, anode and cathodes move together on the tick edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 3'd0;
      anode       <= ANODE_RESET;
      data        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (tick) begin
        idx   <= idx_next;
        anode <= ~(ANODE_ONE << idx_next);
        data  <= data_next;
      end
    end
  end

  // Shadow capture on handshake, promotion to active at the frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= FRAME_RESET;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= '{value: wr_value, dp: wr_dp, blank: wr_blank};
      pending <= 1'b1;
    end else if (swap) begin
      active  <= shadow_eff;
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_frame_buffer.sv
// Self-checking bench for display_frame_buffer with a short digit slot.
module tb_display_frame_buffer;

  localparam int TD    = 4;
  localparam int FRAME = TD * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_value;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_blank;
  logic [7:0]  anode;
  logic [7:0]  data;
  logic        frame_start;

  always #5 clk = ~clk;

  display_frame_buffer #(.TICK_DIV(TD), .NUM_DIGITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_value    (wr_value),
    .wr_dp       (wr_dp),
    .wr_blank    (wr_blank),
    .anode       (anode),
    .data        (data),
    .frame_start (frame_start)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: edges since reset, displayed frame, pending frame
  logic [6:0]  hex7_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_n;
  logic [31:0] m_val, s_val;
  logic [7:0]  m_dp, m_blank, s_dp, s_blank;
  bit          m_pend;

  function automatic int m_idx();
    return (m_n / TD) % 8;
  endfunction

  function automatic logic [7:0] lz_mask(input logic [31:0] v);
    int         h;
    logic [7:0] m;
    h = 0;
    for (int k = 0; k < 8; k++) if (v[4*k +: 4] != 4'h0) h = k;
    m = 8'hFF;
    m = m << (h + 1);
    return m;
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    if (m_blank[k]) return 8'hFF;
    return {~m_dp[k], hex7_tbl[m_val[4*k +: 4]]};
  endfunction

  task automatic model_reset();
    m_n = 0; m_val = '0; m_dp = '0; m_blank = 8'hFF; m_pend = 0;
    s_val = '0; s_dp = '0; s_blank = '0;
  endtask

  task automatic model_edge();
    bit acc, wrap;
    acc  = wr_valid && !m_pend;
    wrap = ((m_n + 1) % FRAME) == 0;
    m_n++;
    if (wrap && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_blank = s_blank;
`ifdef LEADING_ZERO_BLANK_EN
      m_blank = s_blank | lz_mask(s_val);
`endif
      m_pend = 0;
    end
    if (acc) begin
      s_val = wr_value; s_dp = wr_dp; s_blank = wr_blank; m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] an;
    an = ~(8'h01 << m_idx());
    check_eq("anode", 32'(anode), 32'(an));
    check_eq("data", 32'(data), 32'(exp_seg(m_idx())));
    check_eq("wr_ready", 32'(wr_ready), 32'(!m_pend));
    check_eq("frame_start", 32'(frame_start), 32'(m_n > 0 && (m_n % FRAME) == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idx(input int k);
    int b = 0;
    while (m_idx() != k && b < 64) begin step(); b++; end
    check_eq("wait_idx", 32'(m_idx()), 32'(k));
  endtask

  task automatic wait_frame();
    int b = 0;
    while (frame_start !== 1'b1 && b < 2 * FRAME) begin step(); b++; end
    check_eq("wait_frame", 32'(frame_start), 32'd1);
  endtask

  task automatic write_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
    wr_value = v; wr_dp = dp; wr_blank = bl; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic random_inputs();
    wr_valid = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 3) == 0) return;
    wr_dp = 8'h00; wr_blank = 8'h00;
    case ($urandom_range(0, 7))
      0: wr_value = 32'h76543210;
      1: wr_value = 32'h11111111;
      2: wr_value = 32'h22222222;
      3: begin wr_value = 32'h88888888; wr_blank = 8'h80; wr_dp = 8'h01; end
      4: wr_value = 32'h00000A05;
      5: wr_value = 32'h0;
      default: begin
        wr_value = $urandom;
        wr_dp    = 8'($urandom);
        wr_blank = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
      end
    endcase
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_valid = 1'b0; wr_value = '0; wr_dp = '0; wr_blank = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_anode", 32'(anode), 32'h0FE);
    check_eq("rst_data", 32'(data), 32'h0FF);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_fs", 32'(frame_start), 32'd0);
    wr_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_held", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    reset = 1'b1;

    // Idle scan with an all-blank frame
    repeat (40) step();

    // Basic write at digit 3
    wait_idx(3);
    write_frame(32'h76543210, 8'h00, 8'h00);
    wait_frame();
    check_eq("basic_d0", 32'(data), 32'h0C0);
    check_eq("basic_a0", 32'(anode), 32'h0FE);
    wait_idx(1);
    check_eq("basic_d1", 32'(data), 32'h0F9);
    wait_idx(2);
    check_eq("basic_d2", 32'(data), 32'h0A4);

    // Back-pressure: second frame held until the first is promoted
    wr_value = 32'h11111111; wr_dp = 8'h00; wr_blank = 8'h00; wr_valid = 1'b1;
    step();
    wr_value = 32'h22222222;
    check_eq("bp_ready_low", 32'(wr_ready), 32'd0);
    wait_frame();
    check_eq("bp_frame_n", 32'(data), 32'h0F9);
    check_eq("bp_ready_up", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check_eq("bp_accept", 32'(wr_ready), 32'd0);
    wait_frame();
    check_eq("bp_frame_n1", 32'(data), 32'h0A4);

    // Decimal point and blank masks
    write_frame(32'h88888888, 8'h01, 8'h80);
    wait_frame();
    check_eq("mask_d0", 32'(data), 32'h000);
    wait_idx(3);
    check_eq("mask_d3", 32'(data), 32'h080);
    wait_idx(7);
    check_eq("mask_d7", 32'(data), 32'h0FF);

    // Leading zero handling
    write_frame(32'h00000A05, 8'h00, 8'h00);
    wait_frame();
    check_eq("lz_d0", 32'(data), 32'h092);
    wait_idx(2);
    check_eq("lz_d2", 32'(data), 32'h088);
    wait_idx(3);
`ifdef LEADING_ZERO_BLANK_EN
    check_eq("lz_d3", 32'(data), 32'h0FF);
`else
    check_eq("lz_d3", 32'(data), 32'h0C0);
`endif

    // Asynchronous reset mid-frame with a frame pending
    wait_idx(1);
    write_frame(32'h33333333, 8'hFF, 8'h00);
    wait_idx(5);
    check_eq("mid_pending", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_anode", 32'(anode), 32'h0FE);
    check_eq("mid_rst_data", 32'(data), 32'h0FF);
    check_eq("mid_rst_ready", 32'(wr_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    repeat (FRAME + 8) step();
    check_eq("mid_no_old", 32'(data), 32'h0FF);

    // Randomized traffic
    repeat (2500) begin
      random_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
